// File: rtl/nibble_pack_pkg.sv
// Shared sizes and FSM encoding for the nibble packer.
// Widths derive from the default nibble, word and timeout sizes.
package nibble_pack_pkg;

    localparam int NIB_W_DEF   = 4;
    localparam int NIBS_DEF    = 4;
    localparam int DATA_W_DEF  = NIB_W_DEF * NIBS_DEF;
    localparam int TIMEOUT_DEF = 8;
    localparam int IDX_W       = $clog2(NIBS_DEF + 1);
    localparam int TO_W        = $clog2(TIMEOUT_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_word_packer_pk_timeout_cnt.sv
// Idle-cycle counter for the packer: synchronous clear, saturating increment, terminal flag.
// Zero latency on tc; counting holds at TIMEOUT-1 because the owner leaves FILL there.
module pk_timeout_cnt
    import nibble_pack_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = TO_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_word_packer.sv
// Packs a 4-bit nibble stream into 16-bit words; registered outputs, one cycle after the completing accept.
// s_ready drops only in reset and the one-cycle FLUSH; NIBBLE_PACK_REPLICATE_PAD_EN selects replicate padding.
module nibble_word_packer
    import nibble_pack_pkg::*;
#(
    parameter int NIB_W   = NIB_W_DEF,
    parameter int NIBS    = NIBS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [NIB_W-1:0]        s_data,
    input  logic                    s_eop,
    output logic [NIB_W*NIBS-1:0]   data_final,
    output logic                    pk_valid,
    output logic                    pk_last,
    output logic                    pk_err
);

    localparam int DATA_W = NIB_W * NIBS;
    localparam int IW     = $clog2(NIBS + 1);
    localparam int TW     = $clog2(TIMEOUT);

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [DATA_W-1:0] acc, acc_nxt, word;
    logic [NIB_W-1:0]  pad;
    logic              accept, tc, last_slot;
    logic              emit, flush, drop, last_nxt;
    int                nfill;

    assign s_ready   = !rst && (state != FLUSH);
    assign accept    = s_valid && s_ready;
    assign last_slot = (idx == IW'(NIBS - 1));

    pk_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (TW)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (accept || (state != FILL)),
        .inc ((state == FILL) && !accept),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (s_eop || last_slot) begin
                        idx_nxt = '0;
                    end else begin
                        state_nxt = FILL;
                        idx_nxt   = idx + 1'b1;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (s_eop) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else if (last_slot) begin
                        idx_nxt = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else if (tc) begin
                    // An empty word after a full one is never flushed, just abandoned.
                    state_nxt = (idx != '0) ? FLUSH : IDLE;
                    idx_nxt   = '0;
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        emit  = accept && (s_eop || last_slot);
        flush = (state == FILL) && !accept && tc && (idx != '0);
        drop  = (state == FILL) && !accept && tc && (idx == '0);

        if (flush || drop)  last_nxt = 1'b1;
        else if (emit)      last_nxt = s_eop;
        else if (accept)    last_nxt = 1'b0;
        else                last_nxt = pk_last;

        acc_nxt = acc;
        for (int i = 0; i < NIBS; i++) begin
            if (accept && (i == int'(idx))) acc_nxt[i*NIB_W +: NIB_W] = s_data;
        end
        nfill = int'(idx) + (accept ? 1 : 0);

`ifdef NIBBLE_PACK_REPLICATE_PAD_EN
        pad = s_data;
        for (int i = 0; i < NIBS; i++) begin
            if (i == nfill - 1) pad = acc_nxt[i*NIB_W +: NIB_W];
        end
`else
        pad = '0;
`endif

        word = '0;
        for (int i = 0; i < NIBS; i++) begin
            word[i*NIB_W +: NIB_W] = (i < nfill) ? acc_nxt[i*NIB_W +: NIB_W] : pad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            acc        <= '0;
            data_final <= '0;
            pk_valid   <= 1'b0;
            pk_last    <= 1'b1;
            pk_err     <= 1'b0;
        end else begin
            idx      <= idx_nxt;
            acc      <= acc_nxt;
            pk_valid <= emit || flush;
            pk_err   <= flush;
            pk_last  <= last_nxt;
            if (emit || flush) data_final <= word;
        end
    end

endmodule

// File: tb/tb_nibble_word_packer.sv
// Randomized and directed bench for nibble_word_packer against a queue-based reference model.
module tb_nibble_word_packer;

    localparam int NIBS    = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_data;
    logic        s_eop;
    logic [15:0] data_final;
    logic        pk_valid;
    logic        pk_last;
    logic        pk_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    nibble_word_packer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_eop      (s_eop),
        .data_final (data_final),
        .pk_valid   (pk_valid),
        .pk_last    (pk_last),
        .pk_err     (pk_err)
    );

    always #5 clk = ~clk;

    // Reference model: a word is the list of nibbles accepted since the last emit.
    typedef struct {
        logic [15:0] d;
        bit          l;
        bit          e;
        int          cyc;
    } ent_t;

    logic [3:0]  mq[$];
    ent_t        log_q[$];
    bit          in_pkt = 1'b0;
    bit          m_flush = 1'b0;
    int          gap = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    logic [15:0] exp_data = '0;
    bit          exp_valid = 1'b0;
    bit          exp_last = 1'b1;
    bit          exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic emit_word(input bit lst, input bit er);
        logic [15:0] w;
        logic [3:0]  p;
        p = 4'h0;
`ifdef NIBBLE_PACK_REPLICATE_PAD_EN
        p = mq[mq.size() - 1];
`endif
        for (int i = 0; i < NIBS; i++) w[i*4 +: 4] = (i < mq.size()) ? mq[i] : p;
        exp_data  = w;
        exp_valid = 1'b1;
        exp_last  = lst;
        exp_err   = er;
        mq.delete();
        log_q.push_back('{w, lst, er, cyc});
    endtask

    always @(posedge clk) begin
        bit acc;
        cyc++;
        if (rst) begin
            mq.delete();
            in_pkt = 1'b0; gap = 0; m_flush = 1'b0;
            exp_data = '0; exp_valid = 1'b0; exp_last = 1'b1; exp_err = 1'b0;
        end else begin
            acc = s_valid && !m_flush;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (m_flush) begin
                m_flush = 1'b0;
            end else if (acc) begin
                mq.push_back(s_data);
                gap = 0;
                last_acc_cyc = cyc;
                if (s_eop || mq.size() == NIBS) begin
                    emit_word(s_eop, 1'b0);
                    in_pkt = !s_eop;
                end else begin
                    in_pkt   = 1'b1;
                    exp_last = 1'b0;
                end
            end else if (in_pkt) begin
                gap++;
                if (gap == TIMEOUT) begin
                    gap = 0; in_pkt = 1'b0; exp_last = 1'b1;
                    if (mq.size() > 0) begin
                        emit_word(1'b1, 1'b1);
                        m_flush = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready",    32'(s_ready),    32'(!rst && !m_flush));
            chk("data_final", 32'(data_final), 32'(exp_data));
            chk("pk_valid",   32'(pk_valid),   32'(exp_valid));
            chk("pk_last",    32'(pk_last),    32'(exp_last));
            chk("pk_err",     32'(pk_err),     32'(exp_err));
        end
    end

    task automatic send(input logic [3:0] nib, input bit eop);
        bit ok;
        int n;
        n = 0;
        s_valid = 1'b1; s_data = nib; s_eop = eop;
        do begin
            #1; ok = s_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 30);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: nibble %0h not accepted in 30 cycles", nib);
        end
        s_valid = 1'b0; s_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0; s_eop = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_rst();
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w_ab, w_56, w_34;
        int p;
`ifdef NIBBLE_PACK_REPLICATE_PAD_EN
        w_ab = 16'hBBBA; w_56 = 16'h6665; w_34 = 16'h4443;
`else
        w_ab = 16'h00BA; w_56 = 16'h0065; w_34 = 16'h0043;
`endif
        rst = 1'b1; s_valid = 1'b0; s_data = 4'h0; s_eop = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_ready", 32'(s_ready),    32'd0);
        chk("rst_data",  32'(data_final), 32'h0);
        chk("rst_last",  32'(pk_last),    32'd1);
        chk("rst_valid", 32'(pk_valid),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two words from one 8-nibble packet.
        log_q.delete();
        for (int i = 1; i <= 8; i++) send(4'(i), i == 8);
        idle(3);
        chk("p8_cnt", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("p8_w0",   32'(log_q[0].d), 32'h4321);
            chk("p8_l0",   32'(log_q[0].l), 32'd0);
            chk("p8_w1",   32'(log_q[1].d), 32'h8765);
            chk("p8_l1",   32'(log_q[1].l), 32'd1);
            chk("p8_err",  32'(log_q[0].e | log_q[1].e), 32'd0);
            chk("p8_gap",  32'(log_q[1].cyc - log_q[0].cyc), 32'd4);
        end

        // Short packet, padded.
        log_q.delete();
        send(4'hA, 1'b0); send(4'hB, 1'b1);
        idle(2);
        chk("ab_cnt", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) begin
            chk("ab_w", 32'(log_q[0].d), 32'(w_ab));
            chk("ab_l", 32'(log_q[0].l), 32'd1);
        end

        // Timeout flush.
        log_q.delete();
        send(4'h5, 1'b0); send(4'h6, 1'b0);
        idle(12);
        chk("to_cnt", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) begin
            chk("to_w",   32'(log_q[0].d), 32'(w_56));
            chk("to_err", 32'(log_q[0].e), 32'd1);
            chk("to_l",   32'(log_q[0].l), 32'd1);
            chk("to_lat", 32'(log_q[0].cyc - last_acc_cyc), 32'd8);
        end

        // Accept on the last allowed cycle restarts the timeout.
        log_q.delete();
        send(4'h3, 1'b0);
        idle(7);
        send(4'h4, 1'b0);
        idle(3);
        chk("rs_noflush", 32'(log_q.size()), 32'd0);
        idle(8);
        chk("rs_cnt", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) begin
            chk("rs_w",   32'(log_q[0].d), 32'(w_34));
            chk("rs_lat", 32'(log_q[0].cyc - last_acc_cyc), 32'd8);
        end

        // Reset mid-word discards it.
        log_q.delete();
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0);
        pulse_rst();
        chk("mr_data", 32'(data_final), 32'h0);
        chk("mr_last", 32'(pk_last),    32'd1);
        send(4'h9, 1'b0); send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b1);
        idle(2);
        chk("mr_cnt", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) chk("mr_w", 32'(log_q[0].d), 32'hCBA9);

        // Continuous stream across word boundaries.
        log_q.delete();
        for (int i = 1; i <= 12; i++) send(4'(i), i == 12);
        idle(2);
        chk("st_cnt", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("st_w2",  32'(log_q[2].d), 32'hCBA9);
            chk("st_g01", 32'(log_q[1].cyc - log_q[0].cyc), 32'd4);
            chk("st_g12", 32'(log_q[2].cyc - log_q[1].cyc), 32'd4);
        end

        // Full word then silence: abandon the empty word without a strobe.
        log_q.delete();
        for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
        chk("fw_last_mid", 32'(pk_last), 32'd0);
        idle(12);
        chk("fw_cnt",  32'(log_q.size()), 32'd1);
        chk("fw_last", 32'(pk_last), 32'd1);

        // Random traffic with dense, sparse and starved phases.
        for (int i = 0; i < 900; i++) begin
            p = ((i / 40) % 3 == 0) ? 90 : ((i / 40) % 3 == 1) ? 45 : 8;
            s_valid = ($urandom_range(99) < p);
            s_data  = 4'($urandom);
            s_eop   = ($urandom_range(5) == 0);
            rst     = ($urandom_range(299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle(12);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
